// File: rtl/multi_tone_sample_gen_if.sv
// Channel-config write port, run controls and mixed sample output of
// multi_tone_sample_gen. master: config/control source, slave: the generator.
interface multi_tone_sample_gen_if #(
    parameter int NUM_CH   = 2,
    parameter int PHASE_WD = 24,
    parameter int GAIN_WD  = 8,
    parameter int OUT_WD   = 24
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                en_i;
    logic                load_i;
    logic                cfg_we_i;
    logic [CH_W-1:0]     cfg_ch_i;
    logic [PHASE_WD-1:0] cfg_step_i;
    logic [1:0]          cfg_mode_i;
    logic [GAIN_WD-1:0]  cfg_gain_i;
    logic                cfg_phrst_i;
    logic [OUT_WD-1:0]   sample_o;
    logic                sample_valid_o;
    logic                clip_o;

    modport master (
        output en_i, load_i, cfg_we_i, cfg_ch_i, cfg_step_i,
        output cfg_mode_i, cfg_gain_i, cfg_phrst_i,
        input  sample_o, sample_valid_o, clip_o
    );

    modport slave (
        input  en_i, load_i, cfg_we_i, cfg_ch_i, cfg_step_i,
        input  cfg_mode_i, cfg_gain_i, cfg_phrst_i,
        output sample_o, sample_valid_o, clip_o
    );
endinterface

// File: rtl/multi_tone_sample_gen.sv
// N-channel test-tone generator: per-channel phase accumulator, waveform
// (sine/square/triangle/saw), gain; mixed, saturated, one sample per sample_clk.
// Ports: sample_clk, rst_ni (async, active-low), bus (slave modport):
//   en_i advance, load_i output update, cfg_* channel write, sample_o,
//   sample_valid_o, clip_o.
// Option macro DITHER_EN: TPDF dither from a 16-bit LFSR in the low
//   OUT_WD-SAMP_WD bits, re-saturated; undefined leaves those bits 0.
// The sine ROM is built at elaboration from
//   round((2^(SAMP_WD-1)-1)*sin(2*pi*k/2^LUT_AW)).
module multi_tone_sample_gen #(
    parameter int NUM_CH   = 2,
    parameter int PHASE_WD = 24,
    parameter int LUT_AW   = 8,
    parameter int SAMP_WD  = 16,
    parameter int GAIN_WD  = 8,
    parameter int OUT_WD   = 24
) (
    input logic                  sample_clk,
    input logic                  rst_ni,
    multi_tone_sample_gen_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } mode_e;

    localparam int  SH     = OUT_WD - SAMP_WD;
    localparam int  SUM_WD = SAMP_WD + $clog2(NUM_CH) + 1;
    localparam int  H      = 2 ** (SAMP_WD - 1);
    localparam real PI     = 3.14159265358979323846;

    localparam logic signed [SAMP_WD-1:0] SQ_POS = SAMP_WD'(H - 1);
    localparam logic signed [SAMP_WD-1:0] SQ_NEG = SAMP_WD'(1 - H);
    localparam logic signed [SAMP_WD+1:0] TRI_HI = (SAMP_WD + 2)'(3 * H - 1);
    localparam logic signed [SAMP_WD+1:0] TRI_LO = (SAMP_WD + 2)'(H);
    localparam logic signed [SUM_WD-1:0]  SUM_MAX = SUM_WD'(H - 1);
    localparam logic signed [SUM_WD-1:0]  SUM_MIN = SUM_WD'(-H);

    logic [PHASE_WD-1:0]       phase_q  [NUM_CH];
    logic [PHASE_WD-1:0]       step_q   [NUM_CH];
    mode_e                     mode_q   [NUM_CH];
    logic [GAIN_WD-1:0]        gain_q   [NUM_CH];
    logic signed [SAMP_WD-1:0] wave_q   [NUM_CH];
    logic signed [SAMP_WD-1:0] scaled_q [NUM_CH];
    logic signed [SAMP_WD-1:0] rom      [2 ** LUT_AW];

    logic signed [OUT_WD-1:0]  sample_q;
    logic                      valid_q;
    logic                      clip_q;
    logic                      cfg_hit;

    function automatic logic signed [SAMP_WD-1:0] sine_at(input int k);
        real x;
        x = real'(H - 1) * $sin(2.0 * PI * real'(k) / real'(2 ** LUT_AW));
        if (x >= 0.0) return SAMP_WD'($rtoi(x + 0.5));
        return SAMP_WD'(-$rtoi(0.5 - x));
    endfunction

    for (genvar k = 0; k < 2 ** LUT_AW; k++) begin : g_rom
        assign rom[k] = sine_at(k);
    end

    // Waveform from the pre-add phase; u is the top SAMP_WD phase bits.
    function automatic logic signed [SAMP_WD-1:0] wave_of(
        input logic [PHASE_WD-1:0] ph,
        input mode_e               m
    );
        logic [SAMP_WD-1:0]        u;
        logic signed [SAMP_WD+1:0] u2;
        u  = ph[PHASE_WD-1 -: SAMP_WD];
        u2 = $signed({1'b0, u, 1'b0});
        unique case (m)
            MODE_SINE:   wave_of = rom[ph[PHASE_WD-1 -: LUT_AW]];
            MODE_SQUARE: wave_of = ph[PHASE_WD-1] ? SQ_NEG : SQ_POS;
            MODE_TRI:    wave_of = SAMP_WD'(u[SAMP_WD-1] ? TRI_HI - u2
                                                         : u2 - TRI_LO);
            MODE_SAW:    wave_of = {~u[SAMP_WD-1], u[SAMP_WD-2:0]};
        endcase
    endfunction

    // Taking the bits above GAIN_WD is the floor of wave*gain/2^GAIN_WD.
    function automatic logic signed [SAMP_WD-1:0] scale(
        input logic signed [SAMP_WD-1:0] w,
        input logic [GAIN_WD-1:0]        g
    );
        logic signed [SAMP_WD+GAIN_WD:0] p;
        p = w * $signed({1'b0, g});
        return p[GAIN_WD +: SAMP_WD];
    endfunction

    assign cfg_hit = bus.cfg_we_i && (32'(bus.cfg_ch_i) < NUM_CH);

    // Config and accumulators; a phase reset write wins over the increment.
    always_ff @(posedge sample_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                phase_q[c]  <= '0;
                step_q[c]   <= '0;
                mode_q[c]   <= MODE_SINE;
                gain_q[c]   <= '0;
                wave_q[c]   <= '0;
                scaled_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_hit && 32'(bus.cfg_ch_i) == c) begin
                    step_q[c] <= bus.cfg_step_i;
                    mode_q[c] <= mode_e'(bus.cfg_mode_i);
                    gain_q[c] <= bus.cfg_gain_i;
                end
                if (cfg_hit && 32'(bus.cfg_ch_i) == c && bus.cfg_phrst_i)
                    phase_q[c] <= '0;
                else if (bus.en_i)
                    phase_q[c] <= phase_q[c] + step_q[c];
                if (bus.en_i) begin
                    wave_q[c]   <= wave_of(phase_q[c], mode_q[c]);
                    scaled_q[c] <= scale(wave_q[c], gain_q[c]);
                end
            end
        end
    end

    logic signed [SUM_WD-1:0]  sum;
    logic signed [SAMP_WD-1:0] sat_s;
    logic                      sat_clip;
    logic signed [OUT_WD-1:0]  shifted;
    logic signed [OUT_WD-1:0]  out_d;
    logic                      clip_d;

    always_comb begin
        sum = '0;
        for (int c = 0; c < NUM_CH; c++)
            sum = sum + SUM_WD'(scaled_q[c]);
        sat_clip = 1'b0;
        sat_s    = SAMP_WD'(sum);
        if (sum > SUM_MAX) begin
            sat_s    = SAMP_WD'(SUM_MAX);
            sat_clip = 1'b1;
        end else if (sum < SUM_MIN) begin
            sat_s    = SAMP_WD'(SUM_MIN);
            sat_clip = 1'b1;
        end
        shifted = OUT_WD'(sat_s) <<< SH;
    end

`ifdef DITHER_EN
    localparam int DSL = (SH >= 4) ? SH - 4 : 0;
    localparam int DSR = (SH >= 4) ? 0 : 4 - SH;
    localparam logic signed [OUT_WD:0] OMAX = {2'b00, {(OUT_WD-1){1'b1}}};
    localparam logic signed [OUT_WD:0] OMIN = {2'b11, {(OUT_WD-1){1'b0}}};

    logic [15:0]             lfsr_q;
    logic [3:0]              nib_q;
    logic signed [OUT_WD:0]  dith;
    logic signed [OUT_WD:0]  dsum;

    always_ff @(posedge sample_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
            nib_q  <= '0;
        end else if (bus.en_i) begin
            lfsr_q <= {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
            nib_q  <= lfsr_q[3:0];
        end
    end

    // Difference of two uniform nibbles gives a triangular PDF.
    always_comb begin
        dith = (OUT_WD + 1)'($signed({1'b0, lfsr_q[3:0]})
                           - $signed({1'b0, nib_q}));
        dith = (dith <<< DSL) >>> DSR;
        dsum = (OUT_WD + 1)'(shifted) + dith;
        out_d  = OUT_WD'(dsum);
        clip_d = sat_clip;
        if (dsum > OMAX) begin
            out_d  = OUT_WD'(OMAX);
            clip_d = 1'b1;
        end else if (dsum < OMIN) begin
            out_d  = OUT_WD'(OMIN);
            clip_d = 1'b1;
        end
    end
`else
    assign out_d  = shifted;
    assign clip_d = sat_clip;
`endif

    always_ff @(posedge sample_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= '0;
            clip_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.en_i & bus.load_i;
            if (bus.en_i && bus.load_i) begin
                sample_q <= out_d;
                clip_q   <= clip_d;
            end
        end
    end

    assign bus.sample_o       = sample_q;
    assign bus.sample_valid_o = valid_q;
    assign bus.clip_o         = clip_q;
endmodule

// File: tb/tb_multi_tone_sample_gen.sv
// Self-checking bench for multi_tone_sample_gen with a sample-level
// reference model (per-channel phase, waveform formulas, delay queue).
module tb_multi_tone_sample_gen;
    localparam int NUM_CH = 2;

    typedef struct {
        bit known;
        int val;
        bit clip;
    } ent_t;

    logic sample_clk = 1'b0;
    logic rst_ni     = 1'b0;

    always #5 sample_clk = ~sample_clk;

    multi_tone_sample_gen_if #(
        .NUM_CH(NUM_CH), .PHASE_WD(24), .GAIN_WD(8), .OUT_WD(24)
    ) bus ();

    multi_tone_sample_gen #(
        .NUM_CH(NUM_CH), .PHASE_WD(24), .LUT_AW(8),
        .SAMP_WD(16), .GAIN_WD(8), .OUT_WD(24)
    ) dut (
        .sample_clk(sample_clk),
        .rst_ni(rst_ni),
        .bus(bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int unsigned m_step  [NUM_CH];
    int unsigned m_phase [NUM_CH];
    int          m_mode  [NUM_CH];
    int          m_gain  [NUM_CH];
    ent_t        pipe_q[$];
    int          exp_val;
    bit          exp_clip;
    bit          exp_valid;
    bit          exp_known;

    function automatic int sine_ref(input int k);
        real x;
        x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 256.0);
        return int'($floor(x + 0.5));
    endfunction

    function automatic ent_t mix_ref();
        ent_t e;
        int sum, w, u;
        sum = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            u = int'(m_phase[c] >> 8);
            case (m_mode[c])
                0: w = sine_ref(int'(m_phase[c] >> 16));
                1: w = (m_phase[c] >= 32'h800000) ? -32767 : 32767;
                2: w = (u < 32768) ? 2 * u - 32768 : 98303 - 2 * u;
                default: w = u - 32768;
            endcase
            sum += (w * m_gain[c]) >>> 8;
        end
        e.known = 1'b1;
        e.clip  = (sum > 32767) || (sum < -32768);
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        e.val = sum * 256;
        return e;
    endfunction

    task automatic model_reset();
        ent_t z;
        for (int c = 0; c < NUM_CH; c++) begin
            m_step[c] = 0; m_phase[c] = 0; m_mode[c] = 0; m_gain[c] = 0;
        end
        z.known = 1'b1; z.val = 0; z.clip = 1'b0;
        pipe_q.delete();
        pipe_q.push_back(z);
        pipe_q.push_back(z);
        exp_val = 0; exp_clip = 0; exp_valid = 0; exp_known = 1;
    endtask

    task automatic model_edge(input bit en, input bit load);
        ent_t e;
        if (en) begin
            pipe_q.push_back(mix_ref());
            for (int c = 0; c < NUM_CH; c++)
                m_phase[c] = (m_phase[c] + m_step[c]) & 32'hFFFFFF;
            e = pipe_q.pop_front();
            if (load) begin
                exp_val = e.val; exp_clip = e.clip; exp_known = e.known;
            end
        end
        exp_valid = en && load;
    endtask

    task automatic tick(input bit en, input bit load);
        bus.en_i   = en;
        bus.load_i = load;
        @(posedge sample_clk);
        model_edge(en, load);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int unsigned step,
                             input int mode, input int gain, input bit phrst);
        bus.en_i        = 1'b0;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_ch_i    = 1'(ch);
        bus.cfg_step_i  = 24'(step);
        bus.cfg_mode_i  = 2'(mode);
        bus.cfg_gain_i  = 8'(gain);
        bus.cfg_phrst_i = phrst;
        @(posedge sample_clk);
        m_step[ch] = step & 32'hFFFFFF;
        m_mode[ch] = mode;
        m_gain[ch] = gain;
        if (phrst) m_phase[ch] = 0;
        foreach (pipe_q[i]) pipe_q[i].known = 1'b0;
        exp_valid = 1'b0;
        #1;
        bus.cfg_we_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        model_reset();
        @(posedge sample_clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        logic [23:0] ev;
        rst_ni = 1'b0;
        model_reset();
        #12;
        tests_run++;
        if (bus.sample_o !== 24'h0 || bus.sample_valid_o !== 1'b0 ||
            bus.clip_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got s=%h v=%b c=%b want 0/0/0",
                     bus.sample_o, bus.sample_valid_o, bus.clip_o);
        end
        @(posedge sample_clk);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1);
            ev = exp_val[23:0];
            tests_run++;
            if (bus.sample_o !== ev || bus.sample_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_zero_gain[%0d]: got s=%h v=%b want %h/1",
                         i, bus.sample_o, bus.sample_valid_o, ev);
            end
        end
    endtask

    task automatic test_square();
        logic [23:0] want [4];
        logic [23:0] ev;
        int seen;
        want = '{24'h3FFF00, 24'h3FFF00, 24'hC00000, 24'hC00000};
        seen = 0;
        cfg_write(0, 32'h400000, 1, 128, 1'b1);
        cfg_write(1, 0, 0, 0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1);
            ev = exp_val[23:0];
            if (exp_known) begin
                tests_run++;
                if (bus.sample_o !== ev || bus.clip_o !== exp_clip) begin
                    tests_failed++;
                    $display("FAIL square_model[%0d]: got %h/%b want %h/%b",
                             i, bus.sample_o, bus.clip_o, ev, exp_clip);
                end
                if (seen < 4) begin
                    tests_run++;
                    if (bus.sample_o !== want[seen] || bus.clip_o !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL square_seq[%0d]: got %h/%b want %h/0",
                                 seen, bus.sample_o, bus.clip_o, want[seen]);
                    end
                    seen++;
                end
            end
        end
    endtask

    task automatic test_clip();
        logic [23:0] ev;
        int seen;
        seen = 0;
        cfg_write(0, 32'h400000, 1, 255, 1'b1);
        cfg_write(1, 32'h400000, 1, 255, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1);
            ev = exp_val[23:0];
            if (exp_known) begin
                tests_run++;
                if (bus.sample_o !== ev || bus.clip_o !== exp_clip) begin
                    tests_failed++;
                    $display("FAIL clip_model[%0d]: got %h/%b want %h/%b",
                             i, bus.sample_o, bus.clip_o, ev, exp_clip);
                end
                if (seen == 0 || seen == 2) begin
                    ev = (seen == 0) ? 24'h7FFF00 : 24'h800000;
                    tests_run++;
                    if (bus.sample_o !== ev || bus.clip_o !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL clip_sat[%0d]: got %h/%b want %h/1",
                                 seen, bus.sample_o, bus.clip_o, ev);
                    end
                end
                seen++;
            end
        end
    endtask

    task automatic test_load_hold();
        logic [23:0] ev;
        apply_reset();
        cfg_write(0, 32'h400000, 1, 128, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            tests_run++;
            if (bus.sample_o !== 24'h0 || bus.sample_valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_hold[%0d]: got %h/%b want 000000/0",
                         i, bus.sample_o, bus.sample_valid_o);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1);
            ev = exp_val[23:0];
            tests_run++;
            if (!exp_known || bus.sample_o !== ev ||
                bus.sample_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL load_resume[%0d]: got %h/%b want %h/1 k=%b",
                         i, bus.sample_o, bus.sample_valid_o, ev, exp_known);
            end
        end
    endtask

    task automatic test_saw_stall();
        logic [23:0] ev, prev;
        bit have_prev;
        have_prev = 1'b0;
        prev = '0;
        cfg_write(0, 32'h010000, 3, 128, 1'b1);
        cfg_write(1, 0, 0, 0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i >= 6 && i < 11) begin
                tick(1'b0, 1'b1);
                tests_run++;
                if (bus.sample_o !== prev || bus.sample_valid_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL saw_freeze[%0d]: got %h/%b want %h/0",
                             i, bus.sample_o, bus.sample_valid_o, prev);
                end
            end else begin
                tick(1'b1, 1'b1);
                ev = exp_val[23:0];
                if (exp_known) begin
                    tests_run++;
                    if (bus.sample_o !== ev) begin
                        tests_failed++;
                        $display("FAIL saw_model[%0d]: got %h want %h",
                                 i, bus.sample_o, ev);
                    end
                    if (have_prev) begin
                        tests_run++;
                        if (bus.sample_o - prev !== 24'h008000) begin
                            tests_failed++;
                            $display("FAIL saw_step[%0d]: got %h want %h",
                                     i, bus.sample_o - prev, 24'h008000);
                        end
                    end
                    prev = bus.sample_o;
                    have_prev = 1'b1;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] ev;
        bit en, ld;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < NUM_CH; c++)
                cfg_write(c, $urandom & 32'hFFFFFF, int'($urandom % 4),
                          int'($urandom % 256), 1'($urandom % 2));
            for (int i = 0; i < 16; i++) begin
                en = ($urandom % 4) != 0;
                ld = ($urandom % 4) != 0;
                tick(en, ld);
                ev = exp_val[23:0];
                tests_run++;
                if (bus.sample_valid_o !== exp_valid) begin
                    tests_failed++;
                    $display("FAIL rand_valid[%0d.%0d]: got %b want %b",
                             r, i, bus.sample_valid_o, exp_valid);
                end
                if (exp_known) begin
                    tests_run++;
                    if (bus.sample_o !== ev || bus.clip_o !== exp_clip) begin
                        tests_failed++;
                        $display("FAIL rand_sample[%0d.%0d]: got %h/%b want %h/%b",
                                 r, i, bus.sample_o, bus.clip_o, ev, exp_clip);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] ev;
        cfg_write(0, 32'h400000, 1, 128, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        rst_ni = 1'b0;
        #2;
        tests_run++;
        if (bus.sample_o !== 24'h0 || bus.sample_valid_o !== 1'b0 ||
            bus.clip_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got s=%h v=%b c=%b want 0/0/0",
                     bus.sample_o, bus.sample_valid_o, bus.clip_o);
        end
        model_reset();
        @(posedge sample_clk);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1);
            ev = exp_val[23:0];
            tests_run++;
            if (bus.sample_o !== ev || bus.clip_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_after[%0d]: got %h/%b want %h/0",
                         i, bus.sample_o, bus.clip_o, ev);
            end
        end
    endtask

    initial begin
        bus.en_i        = 1'b0;
        bus.load_i      = 1'b0;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_ch_i    = '0;
        bus.cfg_step_i  = '0;
        bus.cfg_mode_i  = '0;
        bus.cfg_gain_i  = '0;
        bus.cfg_phrst_i = 1'b0;
        test_reset();
        test_square();
        test_clip();
        test_load_hold();
        test_saw_stall();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d failed so far",
                 tests_failed);
        $fatal(1);
    end
endmodule
